// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the memory arbiter: one request/response lane per requester.
interface mem_arbiter_if #(
  parameter int REQUESTERS = 2,
  parameter int ADDR_W     = 16
);
  logic [REQUESTERS-1:0] req;
  logic [REQUESTERS-1:0] we;
  logic [REQUESTERS-1:0] bw;
  logic [REQUESTERS-1:0] lock;
  logic [ADDR_W-1:0]     addr  [REQUESTERS];
  logic [15:0]           wdata [REQUESTERS];
  logic [REQUESTERS-1:0] gnt;
  logic [REQUESTERS-1:0] rvalid;
  logic [15:0]           rdata [REQUESTERS];
  logic [REQUESTERS-1:0] err;

  modport master (
    output req, we, bw, lock, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, bw, lock, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with lock sharing one byte-addressable 16-bit memory
// between up to four requesters; steers byte lanes and flags misaligned words.
module mem_arbiter #(
  parameter int REQUESTERS = 2,
  parameter int ADDR_W     = 16,
  parameter int LOCK_MAX   = 8
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      bus,
  output logic              mem_rd,
  output logic [1:0]        mem_wr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  input  logic [15:0]       mem_rd_data
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  // Index of the requester visited at position ofs of the search starting after base.
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input int ofs);
    int s;
    s = (int'(base) + 1 + ofs) % REQUESTERS;
    return 2'(s);
  endfunction

  // Registered state
  logic [1:0]            last_q, last_d;
  logic [CNT_W-1:0]      lock_cnt_q, lock_cnt_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [1:0]            rd_id_q, rd_id_d;
  logic                  rd_bw_q, rd_bw_d;
  logic                  rd_lane_q, rd_lane_d;
  logic [REQUESTERS-1:0] err_q, err_d;

  // Requester inputs padded to four lanes so a 2-bit index is always in range
  logic [3:0]        req_pad_s, we_pad_s, bw_pad_s, lock_pad_s;
  logic [ADDR_W-1:0] addr_pad_s  [4];
  logic [15:0]       wdata_pad_s [4];

  // Arbitration and access decode
  logic              gnt_any_s;
  logic              locked_s;
  logic [1:0]        gnt_idx_s;
  logic [3:0]        gnt_pad_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [15:0]       sel_wdata_s;
  logic              sel_we_s, sel_bw_s;
  logic              misalign_s;
  logic              mem_rd_s;
  logic [1:0]        mem_wr_s;
  logic [ADDR_W-1:0] word_idx_s;
  logic [15:0]       wr_data_s;

  // Read response formatting
  logic [15:0]           fmt_s;
  logic [REQUESTERS-1:0] rvalid_s;
  logic [15:0]           rdata_s [REQUESTERS];

  // Widen the requester bus to four lanes, unused lanes idle.
  always_comb begin
    req_pad_s  = 4'(bus.req);
    we_pad_s   = 4'(bus.we);
    bw_pad_s   = 4'(bus.bw);
    lock_pad_s = 4'(bus.lock);
    for (int i = 0; i < 4; i++) begin
      addr_pad_s[i]  = '0;
      wdata_pad_s[i] = 16'h0000;
    end
    for (int i = 0; i < REQUESTERS; i++) begin
      addr_pad_s[i]  = bus.addr[i];
      wdata_pad_s[i] = bus.wdata[i];
    end
  end

  // Pick the winner: the locked holder while its lock budget lasts, else round-robin after last.
  always_comb begin
    gnt_any_s = 1'b0;
    locked_s  = 1'b0;
    gnt_idx_s = 2'd0;
    // lock_cnt of zero means nothing has been granted since reset, so no holder exists
    if ((lock_cnt_q != '0) && (lock_cnt_q < CNT_W'(LOCK_MAX)) &&
        req_pad_s[last_q] && lock_pad_s[last_q]) begin
      gnt_any_s = 1'b1;
      locked_s  = 1'b1;
      gnt_idx_s = last_q;
    end else begin
      for (int i = 0; i < REQUESTERS; i++) begin
        if (!gnt_any_s && req_pad_s[rr_idx(last_q, i)]) begin
          gnt_any_s = 1'b1;
          gnt_idx_s = rr_idx(last_q, i);
        end
      end
    end
    gnt_pad_s = 4'b0000;
    if (gnt_any_s) begin
      gnt_pad_s[gnt_idx_s] = 1'b1;
    end else begin
      gnt_pad_s = 4'b0000;
    end
  end

  // Drive memory controls for the granted access; misaligned words touch nothing.
  always_comb begin
    sel_addr_s  = addr_pad_s[gnt_idx_s];
    sel_wdata_s = wdata_pad_s[gnt_idx_s];
    sel_we_s    = we_pad_s[gnt_idx_s];
    sel_bw_s    = bw_pad_s[gnt_idx_s];
    misalign_s  = gnt_any_s && !sel_bw_s && sel_addr_s[0];
    word_idx_s  = gnt_any_s ? {1'b0, sel_addr_s[ADDR_W-1:1]} : '0;
    mem_rd_s    = gnt_any_s && !sel_we_s && !misalign_s;
    mem_wr_s    = 2'b00;
    if (gnt_any_s && sel_we_s && !misalign_s) begin
      if (sel_bw_s) begin
        mem_wr_s = sel_addr_s[0] ? 2'b10 : 2'b01;
      end else begin
        mem_wr_s = 2'b11;
      end
    end else begin
      mem_wr_s = 2'b00;
    end
    if (sel_bw_s) begin
      wr_data_s = {sel_wdata_s[7:0], sel_wdata_s[7:0]};
    end else begin
      wr_data_s = sel_wdata_s;
    end
  end

  // Next state: grant history, lock budget, pending read context and error pulse.
  always_comb begin
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    rd_pend_d  = mem_rd_s;
    rd_id_d    = rd_id_q;
    rd_bw_d    = rd_bw_q;
    rd_lane_d  = rd_lane_q;
    err_d      = '0;
    if (gnt_any_s) begin
      last_d     = gnt_idx_s;
      lock_cnt_d = locked_s ? (lock_cnt_q + CNT_W'(1)) : CNT_W'(1);
    end else begin
      last_d     = last_q;
      lock_cnt_d = lock_cnt_q;
    end
    if (mem_rd_s) begin
      rd_id_d   = gnt_idx_s;
      rd_bw_d   = sel_bw_s;
      rd_lane_d = sel_addr_s[0];
    end else begin
      rd_id_d   = rd_id_q;
      rd_bw_d   = rd_bw_q;
      rd_lane_d = rd_lane_q;
    end
    for (int i = 0; i < REQUESTERS; i++) begin
      if (misalign_s && (gnt_idx_s == 2'(i))) begin
        err_d[i] = 1'b1;
      end else begin
        err_d[i] = 1'b0;
      end
    end
  end

  // State register; reset makes the last requester "most recent" so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q     <= 2'(REQUESTERS - 1);
      lock_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_id_q    <= 2'd0;
      rd_bw_q    <= 1'b0;
      rd_lane_q  <= 1'b0;
      err_q      <= '0;
    end else begin
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_id_q    <= rd_id_d;
      rd_bw_q    <= rd_bw_d;
      rd_lane_q  <= rd_lane_d;
      err_q      <= err_d;
    end
  end

  // Format memory read data for the requester whose read is returning this cycle.
  always_comb begin
    if (rd_bw_q) begin
      fmt_s = {8'h00, (rd_lane_q ? mem_rd_data[15:8] : mem_rd_data[7:0])};
    end else begin
      fmt_s = mem_rd_data;
    end
    for (int i = 0; i < REQUESTERS; i++) begin
      rvalid_s[i] = rd_pend_q && (rd_id_q == 2'(i));
      rdata_s[i]  = rvalid_s[i] ? fmt_s : 16'h0000;
    end
  end

  assign bus.gnt    = gnt_pad_s[REQUESTERS-1:0];
  assign bus.rvalid = rvalid_s;
  assign bus.rdata  = rdata_s;
  assign bus.err    = err_q;
  assign mem_rd     = mem_rd_s;
  assign mem_wr     = mem_wr_s;
  assign rd_addr    = word_idx_s;
  assign wr_addr    = word_idx_s;
  assign wr_data    = wr_data_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with two requesters and a small memory model.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        mem_rd;
  logic [1:0]  mem_wr;
  logic [15:0] rd_addr, wr_addr, wr_data;
  logic [15:0] mem_rd_data;
  int          vectors;
  int          miscompares;

  mem_arbiter_if #(.REQUESTERS(2), .ADDR_W(16)) bus ();

  mem_arbiter #(.REQUESTERS(2), .ADDR_W(16), .LOCK_MAX(8)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .rd_addr(rd_addr), .wr_addr(wr_addr),
    .wr_data(wr_data), .mem_rd_data(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: byte-enabled write and one-cycle registered read; reset loads known words.
  logic [15:0] mem [64];
  always @(posedge clk) begin
    if (rst) begin
      mem[1]      <= 16'h5555;
      mem[8]      <= 16'hBEEF;
      mem[16]     <= 16'h1234;
      mem_rd_data <= 16'h0000;
    end else begin
      if (mem_wr[0]) mem[wr_addr[5:0]][7:0]  <= wr_data[7:0];
      if (mem_wr[1]) mem[wr_addr[5:0]][15:8] <= wr_data[15:8];
      if (mem_rd) mem_rd_data <= mem[rd_addr[5:0]];
    end
  end

  task automatic idle();
    bus.req = 2'b00; bus.we = 2'b00; bus.bw = 2'b00; bus.lock = 2'b00;
    bus.addr[0] = 16'h0000; bus.addr[1] = 16'h0000;
    bus.wdata[0] = 16'h0000; bus.wdata[1] = 16'h0000;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (bus.gnt !== 2'b00) begin miscompares++; $display("FAIL reset_gnt got=%b exp=00", bus.gnt); end
    vectors++; if (mem_rd !== 1'b0) begin miscompares++; $display("FAIL reset_mem_rd got=%b exp=0", mem_rd); end
    vectors++; if (mem_wr !== 2'b00) begin miscompares++; $display("FAIL reset_mem_wr got=%b exp=00", mem_wr); end
    vectors++; if (bus.rvalid !== 2'b00) begin miscompares++; $display("FAIL reset_rvalid got=%b exp=00", bus.rvalid); end
    vectors++; if (bus.err !== 2'b00) begin miscompares++; $display("FAIL reset_err got=%b exp=00", bus.err); end
    vectors++; if (bus.rdata[0] !== 16'h0000) begin miscompares++; $display("FAIL reset_rdata0 got=%h exp=0000", bus.rdata[0]); end
  endtask

  task automatic test_word_read();
    next_cycle();
    rst = 1'b0;
    bus.req = 2'b01; bus.addr[0] = 16'h0010;
    #4;
    vectors++; if (bus.gnt !== 2'b01) begin miscompares++; $display("FAIL wr_gnt got=%b exp=01", bus.gnt); end
    vectors++; if (mem_rd !== 1'b1) begin miscompares++; $display("FAIL wr_mem_rd got=%b exp=1", mem_rd); end
    vectors++; if (rd_addr !== 16'h0008) begin miscompares++; $display("FAIL wr_rd_addr got=%h exp=0008", rd_addr); end
    vectors++; if (mem_wr !== 2'b00) begin miscompares++; $display("FAIL wr_mem_wr got=%b exp=00", mem_wr); end
    next_cycle();
    idle();
    #4;
    vectors++; if (bus.rvalid !== 2'b01) begin miscompares++; $display("FAIL wr_rvalid got=%b exp=01", bus.rvalid); end
    vectors++; if (bus.rdata[0] !== 16'hBEEF) begin miscompares++; $display("FAIL wr_rdata0 got=%h exp=beef", bus.rdata[0]); end
    vectors++; if (bus.rdata[1] !== 16'h0000) begin miscompares++; $display("FAIL wr_rdata1 got=%h exp=0000", bus.rdata[1]); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [4];
    exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      if (c == 4) begin
        idle();
      end else begin
        bus.req = 2'b11; bus.addr[0] = 16'h0010; bus.addr[1] = 16'h0020;
      end
      #4;
      if (c < 4) begin
        vectors++; if (bus.gnt !== exp_g[c]) begin miscompares++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", c, bus.gnt, exp_g[c]); end
      end
      if (c > 0) begin
        vectors++; if (bus.rvalid !== exp_g[c-1]) begin miscompares++; $display("FAIL rr_rvalid[%0d] got=%b exp=%b", c, bus.rvalid, exp_g[c-1]); end
        if (exp_g[c-1] == 2'b01) begin
          vectors++; if (bus.rdata[0] !== 16'hBEEF) begin miscompares++; $display("FAIL rr_rdata0[%0d] got=%h exp=beef", c, bus.rdata[0]); end
        end else begin
          vectors++; if (bus.rdata[1] !== 16'h1234) begin miscompares++; $display("FAIL rr_rdata1[%0d] got=%h exp=1234", c, bus.rdata[1]); end
        end
      end
    end
  endtask

  task automatic test_byte_lanes();
    next_cycle();
    bus.req = 2'b01; bus.we = 2'b01; bus.bw = 2'b01; bus.addr[0] = 16'h0021; bus.wdata[0] = 16'h00A5;
    #4;
    vectors++; if (bus.gnt !== 2'b01) begin miscompares++; $display("FAIL bw_gnt got=%b exp=01", bus.gnt); end
    vectors++; if (mem_wr !== 2'b10) begin miscompares++; $display("FAIL bw_mem_wr got=%b exp=10", mem_wr); end
    vectors++; if (wr_data !== 16'hA5A5) begin miscompares++; $display("FAIL bw_wr_data got=%h exp=a5a5", wr_data); end
    vectors++; if (wr_addr !== 16'h0010) begin miscompares++; $display("FAIL bw_wr_addr got=%h exp=0010", wr_addr); end
    vectors++; if (mem_rd !== 1'b0) begin miscompares++; $display("FAIL bw_mem_rd got=%b exp=0", mem_rd); end
    next_cycle();
    bus.we = 2'b00; bus.bw = 2'b01; bus.addr[0] = 16'h0021;
    #4;
    vectors++; if (mem_rd !== 1'b1) begin miscompares++; $display("FAIL br_mem_rd got=%b exp=1", mem_rd); end
    vectors++; if (rd_addr !== 16'h0010) begin miscompares++; $display("FAIL br_rd_addr got=%h exp=0010", rd_addr); end
    next_cycle();
    bus.bw = 2'b00; bus.addr[0] = 16'h0020;
    #4;
    vectors++; if (bus.rvalid !== 2'b01) begin miscompares++; $display("FAIL br_rvalid got=%b exp=01", bus.rvalid); end
    vectors++; if (bus.rdata[0] !== 16'h00A5) begin miscompares++; $display("FAIL br_rdata0 got=%h exp=00a5", bus.rdata[0]); end
    next_cycle();
    idle();
    #4;
    vectors++; if (bus.rvalid !== 2'b01) begin miscompares++; $display("FAIL wd_rvalid got=%b exp=01", bus.rvalid); end
    vectors++; if (bus.rdata[0] !== 16'hA534) begin miscompares++; $display("FAIL wd_rdata0 got=%h exp=a534", bus.rdata[0]); end
  endtask

  task automatic test_misaligned();
    next_cycle();
    bus.req = 2'b11; bus.we = 2'b10; bus.bw = 2'b00;
    bus.addr[1] = 16'h0003; bus.wdata[1] = 16'hFFFF; bus.addr[0] = 16'h0002;
    #4;
    vectors++; if (bus.gnt !== 2'b10) begin miscompares++; $display("FAIL ma_gnt got=%b exp=10", bus.gnt); end
    vectors++; if (mem_wr !== 2'b00) begin miscompares++; $display("FAIL ma_mem_wr got=%b exp=00", mem_wr); end
    vectors++; if (mem_rd !== 1'b0) begin miscompares++; $display("FAIL ma_mem_rd got=%b exp=0", mem_rd); end
    next_cycle();
    bus.req = 2'b01; bus.we = 2'b00;
    #4;
    vectors++; if (bus.gnt !== 2'b01) begin miscompares++; $display("FAIL ma_next_gnt got=%b exp=01", bus.gnt); end
    vectors++; if (bus.err !== 2'b10) begin miscompares++; $display("FAIL ma_err got=%b exp=10", bus.err); end
    vectors++; if (bus.rvalid !== 2'b00) begin miscompares++; $display("FAIL ma_rvalid got=%b exp=00", bus.rvalid); end
    vectors++; if (rd_addr !== 16'h0001) begin miscompares++; $display("FAIL ma_rd_addr got=%h exp=0001", rd_addr); end
    next_cycle();
    idle();
    #4;
    vectors++; if (bus.err !== 2'b00) begin miscompares++; $display("FAIL ma_err_clear got=%b exp=00", bus.err); end
    vectors++; if (bus.rdata[0] !== 16'h5555) begin miscompares++; $display("FAIL ma_word1 got=%h exp=5555", bus.rdata[0]); end
  endtask

  task automatic test_lock();
    logic [1:0] exp_g;
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      bus.req = 2'b11; bus.lock = 2'b10; bus.addr[0] = 16'h0010; bus.addr[1] = 16'h0020;
      #4;
      exp_g = (c == 8) ? 2'b01 : 2'b10;
      vectors++; if (bus.gnt !== exp_g) begin miscompares++; $display("FAIL lock_gnt[%0d] got=%b exp=%b", c, bus.gnt, exp_g); end
    end
    next_cycle();
    idle();
    #4;
    vectors++; if (bus.rvalid !== 2'b10) begin miscompares++; $display("FAIL lock_rvalid got=%b exp=10", bus.rvalid); end
  endtask

  task automatic test_reset_mid_read();
    next_cycle();
    bus.req = 2'b01; bus.addr[0] = 16'h0010;
    #4;
    vectors++; if (bus.gnt !== 2'b01) begin miscompares++; $display("FAIL rm_gnt got=%b exp=01", bus.gnt); end
    next_cycle();
    rst = 1'b1;
    idle();
    #1;
    vectors++; if (bus.rvalid !== 2'b00) begin miscompares++; $display("FAIL rm_rvalid_async got=%b exp=00", bus.rvalid); end
    #3;
    vectors++; if (bus.rdata[0] !== 16'h0000) begin miscompares++; $display("FAIL rm_rdata0 got=%h exp=0000", bus.rdata[0]); end
    next_cycle();
    #4;
    vectors++; if (bus.rvalid !== 2'b00) begin miscompares++; $display("FAIL rm_rvalid_held got=%b exp=00", bus.rvalid); end
    next_cycle();
    rst = 1'b0;
    bus.req = 2'b11; bus.addr[0] = 16'h0010; bus.addr[1] = 16'h0020;
    #4;
    vectors++; if (bus.gnt !== 2'b01) begin miscompares++; $display("FAIL rm_first_gnt got=%b exp=01", bus.gnt); end
    vectors++; if (bus.rvalid !== 2'b00) begin miscompares++; $display("FAIL rm_no_stale got=%b exp=00", bus.rvalid); end
    next_cycle();
    idle();
    #4;
    vectors++; if (bus.rvalid !== 2'b01) begin miscompares++; $display("FAIL rm_post_rvalid got=%b exp=01", bus.rvalid); end
    vectors++; if (bus.rdata[0] !== 16'hBEEF) begin miscompares++; $display("FAIL rm_post_rdata got=%h exp=beef", bus.rdata[0]); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_word_read();
    test_round_robin();
    test_byte_lanes();
    test_misaligned();
    test_lock();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within 100000 time units");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin access controller that shares the single-write, byte-addressable X-Makina memory between up to four requesters (CPU fetch, CPU data, DMA, debug). It grants one access per cycle, converts byte addresses to word indices, steers byte lanes for reads and writes, and flags misaligned word accesses. It sits between the requesters and a `memory` instance configured with `ACTIVE_EDGE=1`, `WORD=16`, `READ_PORTS=1`.

## Interface
- `REQUESTERS`, 2: number of requesters, legal range 2..4.
- `ADDR_W`, 16: byte address width.
- `LOCK_MAX`, 8: maximum consecutive locked grants before a forced release.

- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: asynchronous reset, active-high.
- `req[REQUESTERS]` in 1: access request, held until granted.
- `we[REQUESTERS]` in 1: 1 = write, 0 = read.
- `bw[REQUESTERS]` in 1: 1 = byte access, 0 = word access.
- `lock[REQUESTERS]` in 1: holder asks to keep the grant on its next request.
- `addr[REQUESTERS]` in ADDR_W: byte address.
- `wdata[REQUESTERS]` in 16: write data; for byte writes, bits [7:0] are used.
- `gnt[REQUESTERS]` out 1: combinational one-hot grant in the access cycle.
- `rvalid[REQUESTERS]` out 1: registered; read data valid.
- `rdata[REQUESTERS]` out 16: formatted read data, qualified by `rvalid`.
- `err[REQUESTERS]` out 1: registered one-cycle pulse for a misaligned word access.
- `mem_rd` out 1: memory read enable, port 0.
- `mem_wr` out 2: memory byte write enables.
- `rd_addr`, `wr_addr` out ADDR_W: word index, `{1'b0, addr[ADDR_W-1:1]}`.
- `wr_data` out 16: memory write data.
- `mem_rd_data` in 16: memory read port 0 data.

## Operation
- Arbitration is round-robin. The search starts at index `(last+1) mod REQUESTERS`. `last` is the most recently granted index and resets to `REQUESTERS-1`, so requester 0 wins first.
- Lock rule:
  - If the previous grant went to `k`, `lock[k]=1`, `req[k]=1`, and `lock_cnt < LOCK_MAX`, then `k` is granted again and `lock_cnt` increments.
  - Any non-locked grant, or a grant to a different index, resets `lock_cnt` to 1.
  - When `lock_cnt = LOCK_MAX`, lock is ignored for one arbitration and normal round-robin applies.
- No request pending: `gnt=0`, `mem_rd=0`, `mem_wr=0`, and `last` is unchanged.
- Misaligned access is a granted word access with `addr[0]=1`:
  - The grant is consumed and `last` updates.
  - No `mem_rd` or `mem_wr` is driven.
  - `err[k]` pulses the next cycle and `rvalid[k]` stays 0.
- Write, word: `mem_wr=2'b11`, `wr_data=wdata`.
- Write, byte: `wr_data={wdata[7:0], wdata[7:0]}`.
  - `addr[0]=0` gives `mem_wr=2'b01`.
  - `addr[0]=1` gives `mem_wr=2'b10`.
- Read: `mem_rd=1` and `rd_addr` = word index. The controller registers the requester id, `bw`, and `addr[0]` for formatting.
- Read data formatting:
  - Word read: `rdata = mem_rd_data`.
  - Byte read: `rdata = {8'h00, selected lane}`, where lane 0 is `[7:0]` and lane 1 is `[15:8]`.
- `rdata` of non-selected requesters is 0.
- Read-after-write to the same word in consecutive cycles returns the new data: the write lands at edge N+1 and the read is issued at N+1, sampled at N+2.

## Timing
- Cycle N: `gnt[k]` is asserted combinationally from the inputs. Memory controls are driven the same cycle. The requester may drop or change `req` after the posedge ending cycle N.
- Read latency is 1: `rvalid[k]=1` during cycle N+1 and `rdata[k]` is valid in that cycle. Back-to-back reads give one result per cycle.
- `err[k]` is high in cycle N+1 only.
- Throughput: one access per cycle, with no bubbles between different requesters.
- Reset values: `rvalid=0`, `err=0`, `rdata=0`, `gnt=0`, `mem_rd=0`, `mem_wr=0`, `last=REQUESTERS-1`, `lock_cnt=0`.
- Reset asserted mid-read clears `rvalid` immediately. No stale data is presented after reset releases.
- Inputs are sampled only at posedge. `gnt` may glitch combinationally and must be used only as a synchronous qualifier.

## Test plan
- Reset, then `req[0]` word read with `addr=16'h0010` (memory word 8 = `16'hBEEF`) → `gnt[0]` in cycle 0, `rd_addr=16'h0008`, `rvalid[0]=1` with `rdata[0]=16'hBEEF` in cycle 1.
- `req[0]` and `req[1]` held continuously, reads, no lock → grants alternate 0,1,0,1. Each requester receives `rvalid` one cycle after its own grant.
- Byte write `wdata=16'h00A5` to `addr=16'h0021`, then byte read `addr 16'h0021`, then word read `addr 16'h0020` (prior word `16'h1234`) → `mem_wr=2'b10`, byte read returns `16'h00A5`, word read returns `16'hA534`.
- Word write to `addr=16'h0003` → no `mem_wr`, `err` pulses for one cycle, memory word 1 unchanged, next requester granted the following cycle.
- `req[1]`+`lock[1]` held with `req[0]` held, `LOCK_MAX=8` → 8 consecutive grants to 1, then a grant to 0, then 1 resumes.
- Assert `rst` in the cycle after a read grant → `rvalid` is 0 during and after reset, and the first post-reset grant goes to requester 0.
